// File: rtl/mips_ctrl_pkg.sv
// Purpose : shared types and constants for the multicycle MIPS controller.
// Latency : n/a (types, constants and one pure decode helper).
// Backpr. : n/a.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMRD,
    ST_MEMWB,
    ST_MEMWR,
    ST_RTYPEEX,
    ST_RTYPEWB,
    ST_BEQEX,
    ST_ADDIEX,
    ST_ADDIWB,
    ST_JEX
  } ctrl_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Full control word; the top unpacks it onto individual ports.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: is_legal_op = 1'b1;
      default:                                       is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Purpose : combinational state -> control-word decode for the multicycle controller.
// Latency : 0 cycles (pure combinational from the state register).
// Backpr. : memory stall only gates ir_write/pc_en in FETCH via mem_rdy.
// Ports   : state, op (DECODE only), zero (BEQEX only), mem_rdy -> ctrl word.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  ctrl_state_t state,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_rdy,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        // Only commit the instruction and PC+4 once memory delivers.
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_en     = mem_rdy;
      end
      ST_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = ~is_legal_op(op);
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      ST_BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      ST_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_JEX: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose : multicycle MIPS main controller (Moore FSM) with fetched-instruction counter.
// Latency : lw 5, sw/R-type/addi 4, beq/j 3, illegal 2 cycles; +1 per stalled memory cycle.
// Backpr. : holds FETCH/MEMRD/MEMWR while mem_ready=0 (ignored when USE_MEM_READY=0).
// Ports   : clk, reset (async, high); op, zero, mem_ready in; datapath controls,
//           illegal_op pulse and 32-bit instr_cnt out.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int USE_MEM_READY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        illegal_op,
  output logic [31:0] instr_cnt
);

  ctrl_state_t state;
  ctrl_t       ctrl;
  logic        mem_rdy;

  assign mem_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  // op is only looked at in DECODE and MEMADR; other cycles ignore it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      instr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_rdy) begin
            state     <= ST_DECODE;
            instr_cnt <= instr_cnt + 32'd1;
          end
        end
        ST_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= ST_MEMADR;
            OP_RTYPE:     state <= ST_RTYPEEX;
            OP_BEQ:       state <= ST_BEQEX;
            OP_ADDI:      state <= ST_ADDIEX;
            OP_J:         state <= ST_JEX;
            default:      state <= ST_FETCH;
          endcase
        end
        ST_MEMADR:  state <= (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
        ST_MEMRD:   if (mem_rdy) state <= ST_MEMWB;
        ST_MEMWR:   if (mem_rdy) state <= ST_FETCH;
        ST_RTYPEEX: state <= ST_RTYPEWB;
        ST_ADDIEX:  state <= ST_ADDIWB;
        ST_MEMWB, ST_RTYPEWB, ST_BEQEX, ST_ADDIWB, ST_JEX: state <= ST_FETCH;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  mips_ctrl_outdec u_outdec (
    .state   (state),
    .op      (op),
    .zero    (zero),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign mem_write  = ctrl.mem_write;
  assign iord       = ctrl.iord;
  assign ir_write   = ctrl.ir_write;
  assign pc_en      = ctrl.pc_en;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose : self-checking bench for mips_multicycle_ctrl against an instruction-level model.
// Latency : n/a.
// Backpr. : n/a.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctl_t;

  logic        clk, reset, zero, mem_ready;
  logic [5:0]  op;
  logic        mem_req, mem_write, iord, ir_write, pc_en, alu_src_a;
  logic        reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [31:0] instr_cnt;

  int checks = 0;
  int failures = 0;

  // Model state and per-cycle expectation/stimulus queues.
  logic [31:0] m_cnt;
  ctl_t        q_exp[$];
  logic [5:0]  q_op[$];
  logic        q_mr[$];
  logic        q_z[$];
  logic [31:0] q_cnt[$];
  ctl_t        obs_q[$];
  logic [31:0] cnt_q[$];
  ctrl_state_t st_q[$];

  mips_multicycle_ctrl #(.USE_MEM_READY(1)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal_op(illegal_op), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t sample();
    ctl_t s;
    s = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
         alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op};
    return s;
  endfunction

  function automatic logic legal(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  task automatic push(input ctl_t r, input logic [5:0] o, input logic mr, input logic z);
    q_exp.push_back(r); q_op.push_back(o); q_mr.push_back(mr); q_z.push_back(z);
    q_cnt.push_back(m_cnt);
  endtask

  task automatic clear_rows();
    q_exp.delete(); q_op.delete(); q_mr.delete(); q_z.delete(); q_cnt.delete();
    obs_q.delete(); cnt_q.delete(); st_q.delete();
  endtask

  // Expected cycle-by-cycle behaviour of one instruction starting in FETCH.
  // wf/wm = stall cycles in FETCH / data access. op and zero are scrambled
  // wherever the controller must not be looking at them.
  task automatic build_rows(input logic [5:0] o, input logic z, input int wf, input int wm);
    ctl_t r;
    for (int i = 0; i < wf; i++) begin
      r = '0; r.mem_req = 1; r.alu_src_b = 2'b01;
      push(r, 6'($urandom), 1'b0, 1'($urandom));
    end
    r = '0; r.mem_req = 1; r.alu_src_b = 2'b01; r.ir_write = 1; r.pc_en = 1;
    push(r, 6'($urandom), 1'b1, 1'($urandom));
    m_cnt = m_cnt + 32'd1;
    r = '0; r.alu_src_b = 2'b11; r.illegal_op = ~legal(o);
    push(r, o, 1'($urandom), 1'($urandom));
    case (o)
      6'b100011, 6'b101011: begin
        r = '0; r.alu_src_a = 1; r.alu_src_b = 2'b10;
        push(r, o, 1'($urandom), 1'($urandom));
        for (int i = 0; i <= wm; i++) begin
          r = '0; r.mem_req = 1; r.iord = 1; r.mem_write = (o == 6'b101011);
          push(r, 6'($urandom), (i == wm), 1'($urandom));
        end
        if (o == 6'b100011) begin
          r = '0; r.mem_to_reg = 1; r.reg_write = 1;
          push(r, 6'($urandom), 1'($urandom), 1'($urandom));
        end
      end
      6'b000000: begin
        r = '0; r.alu_src_a = 1; r.alu_op = 2'b10;
        push(r, 6'($urandom), 1'($urandom), 1'($urandom));
        r = '0; r.reg_dst = 1; r.reg_write = 1;
        push(r, 6'($urandom), 1'($urandom), 1'($urandom));
      end
      6'b000100: begin
        r = '0; r.alu_src_a = 1; r.alu_op = 2'b01; r.pc_src = 2'b01; r.pc_en = z;
        push(r, 6'($urandom), 1'($urandom), z);
      end
      6'b001000: begin
        r = '0; r.alu_src_a = 1; r.alu_src_b = 2'b10;
        push(r, 6'($urandom), 1'($urandom), 1'($urandom));
        r = '0; r.reg_write = 1;
        push(r, 6'($urandom), 1'($urandom), 1'($urandom));
      end
      6'b000010: begin
        r = '0; r.pc_src = 2'b10; r.pc_en = 1;
        push(r, 6'($urandom), 1'($urandom), 1'($urandom));
      end
      default: ;
    endcase
  endtask

  // Entered and left at a falling edge; observes 1 time unit after driving.
  task automatic play_rows();
    for (int i = 0; i < q_exp.size(); i++) begin
      op = q_op[i]; mem_ready = q_mr[i]; zero = q_z[i];
      #1;
      obs_q.push_back(sample());
      cnt_q.push_back(instr_cnt);
      st_q.push_back(dut.state);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    op = '0; zero = 0; mem_ready = 0; reset = 0;
    #1 reset = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sample() !== ctl_t'(0)) begin
      failures++; $display("FAIL reset_outputs: got %h want 0", sample());
    end
    checks++;
    if (instr_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_cnt: got %h want 0", instr_cnt);
    end
    @(negedge clk);
    reset = 0; mem_ready = 1;
    #1;
    checks++;
    if (sample() !== ctl_t'(0) || dut.state !== ST_IDLE) begin
      failures++; $display("FAIL post_reset_idle: got ctl=%h st=%s want 0/IDLE", sample(), dut.state.name());
    end
    @(negedge clk);
    m_cnt = '0;
  endtask

  task automatic test_lw();
    ctrl_state_t exp_st [5] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB};
    clear_rows();
    build_rows(6'b100011, 1'b0, 0, 0);
    play_rows();
    foreach (q_exp[i]) begin
      checks++;
      if (obs_q[i] !== q_exp[i] || cnt_q[i] !== q_cnt[i] || st_q[i] !== exp_st[i]) begin
        failures++;
        $display("FAIL lw row %0d: got ctl=%h cnt=%h st=%s want ctl=%h cnt=%h st=%s",
                 i, obs_q[i], cnt_q[i], st_q[i].name(), q_exp[i], q_cnt[i], exp_st[i].name());
      end
    end
    checks++;
    if (obs_q[4].reg_write !== 1'b1 || obs_q[4].mem_to_reg !== 1'b1) begin
      failures++; $display("FAIL lw_writeback: got rw=%b m2r=%b want 1/1", obs_q[4].reg_write, obs_q[4].mem_to_reg);
    end
    checks++;
    if (instr_cnt !== 32'd1) begin
      failures++; $display("FAIL lw_cnt: got %0d want 1", instr_cnt);
    end
  endtask

  task automatic test_beq();
    clear_rows();
    build_rows(6'b000100, 1'b1, 0, 0);
    build_rows(6'b000100, 1'b0, 1, 0);
    play_rows();
    foreach (q_exp[i]) begin
      checks++;
      if (obs_q[i] !== q_exp[i] || cnt_q[i] !== q_cnt[i]) begin
        failures++;
        $display("FAIL beq row %0d: got ctl=%h cnt=%h want ctl=%h cnt=%h", i, obs_q[i], cnt_q[i], q_exp[i], q_cnt[i]);
      end
    end
    checks++;
    if (obs_q[2].pc_en !== 1'b1 || obs_q[2].pc_src !== 2'b01 || obs_q[6].pc_en !== 1'b0) begin
      failures++;
      $display("FAIL beq_branch: got taken pc_en=%b pc_src=%b untaken pc_en=%b want 1/01/0",
               obs_q[2].pc_en, obs_q[2].pc_src, obs_q[6].pc_en);
    end
  endtask

  task automatic test_sw_wait();
    int wr_cycles;
    clear_rows();
    build_rows(6'b101011, 1'b0, 0, 3);
    play_rows();
    wr_cycles = 0;
    foreach (q_exp[i]) begin
      if (obs_q[i].mem_write === 1'b1) wr_cycles++;
      checks++;
      if (obs_q[i] !== q_exp[i] || cnt_q[i] !== q_cnt[i]) begin
        failures++;
        $display("FAIL sw row %0d: got ctl=%h cnt=%h want ctl=%h cnt=%h", i, obs_q[i], cnt_q[i], q_exp[i], q_cnt[i]);
      end
    end
    checks++;
    if (wr_cycles != 4) begin
      failures++; $display("FAIL sw_write_len: got %0d cycles want 4", wr_cycles);
    end
    mem_ready = 0;
    #1;
    checks++;
    if (dut.state !== ST_FETCH || mem_req !== 1'b1 || iord !== 1'b0 || mem_write !== 1'b0) begin
      failures++; $display("FAIL sw_then_fetch: got st=%s req=%b iord=%b wr=%b want FETCH/1/0/0",
                           dut.state.name(), mem_req, iord, mem_write);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int pulses;
    clear_rows();
    build_rows(6'b111111, 1'b0, 0, 0);
    play_rows();
    pulses = 0;
    foreach (q_exp[i]) begin
      if (obs_q[i].illegal_op === 1'b1) pulses++;
      checks++;
      if (obs_q[i] !== q_exp[i] || obs_q[i].reg_write !== 1'b0 || obs_q[i].mem_write !== 1'b0) begin
        failures++; $display("FAIL illegal row %0d: got ctl=%h want ctl=%h", i, obs_q[i], q_exp[i]);
      end
    end
    checks++;
    if (pulses != 1 || st_q[1] !== ST_DECODE) begin
      failures++; $display("FAIL illegal_pulse: got %0d pulses st=%s want 1 in DECODE", pulses, st_q[1].name());
    end
    #1;
    checks++;
    if (dut.state !== ST_FETCH) begin
      failures++; $display("FAIL illegal_next: got st=%s want FETCH", dut.state.name());
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] o;
    int bad;
    clear_rows();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do o = 6'($urandom); while (legal(o));
      end else begin
        o = ops[$urandom_range(0, 5)];
      end
      build_rows(o, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    play_rows();
    bad = 0;
    foreach (q_exp[i]) begin
      checks++;
      if (obs_q[i] !== q_exp[i] || cnt_q[i] !== q_cnt[i]) begin
        failures++;
        if (bad < 10)
          $display("FAIL random row %0d: got ctl=%h cnt=%h want ctl=%h cnt=%h", i, obs_q[i], cnt_q[i], q_exp[i], q_cnt[i]);
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid_access();
    clear_rows();
    build_rows(6'b100011, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      op = q_op[i]; mem_ready = q_mr[i]; zero = q_z[i];
      @(negedge clk);
    end
    op = 6'b100011; mem_ready = 0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || iord !== 1'b1) begin
      failures++; $display("FAIL mid_pre: got req=%b iord=%b want 1/1", mem_req, iord);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (sample() !== ctl_t'(0) || instr_cnt !== 32'd0 || dut.state !== ST_IDLE) begin
      failures++; $display("FAIL mid_abort: got ctl=%h cnt=%h st=%s want 0/0/IDLE", sample(), instr_cnt, dut.state.name());
    end
    mem_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (ir_write !== 1'b0 || pc_en !== 1'b0 || reg_write !== 1'b0) begin
      failures++; $display("FAIL mid_no_commit: got ir=%b pc=%b rw=%b want 0/0/0", ir_write, pc_en, reg_write);
    end
    @(negedge clk);
    reset = 0;
    #1;
    checks++;
    if (dut.state !== ST_IDLE || sample() !== ctl_t'(0)) begin
      failures++; $display("FAIL mid_idle: got st=%s ctl=%h want IDLE/0", dut.state.name(), sample());
    end
    @(negedge clk);
    m_cnt = '0;
  endtask

  task automatic test_wrap();
    mem_ready = 0;
    force dut.instr_cnt = 32'hFFFF_FFFF;
    #1 release dut.instr_cnt;
    #1;
    checks++;
    if (instr_cnt !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_preload: got %h want ffffffff", instr_cnt);
    end
    @(negedge clk);
    m_cnt = 32'hFFFF_FFFF;
    clear_rows();
    build_rows(6'b000010, 1'b0, 0, 0);
    play_rows();
    foreach (q_exp[i]) begin
      checks++;
      if (obs_q[i] !== q_exp[i] || cnt_q[i] !== q_cnt[i]) begin
        failures++;
        $display("FAIL wrap row %0d: got ctl=%h cnt=%h want ctl=%h cnt=%h", i, obs_q[i], cnt_q[i], q_exp[i], q_cnt[i]);
      end
    end
    checks++;
    if (instr_cnt !== 32'd0) begin
      failures++; $display("FAIL wrap_cnt: got %h want 0", instr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_sw_wait();
    test_illegal();
    test_back_to_back();
    test_reset_mid_access();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter USE_MEM_READY, default 1, meaning 1 = honour mem_ready and 0 = treat mem_ready as constant 1.
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  6  opcode field of the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  write strobe; valid only with mem_req.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  instruction register load.
- pc_en  output  1  PC load enable.
- pc_src  output  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- alu_op  output  2  drives the ALU-control decoder: 00 = add, 01 = sub, 10 = funct.
- reg_dst  output  1  0 = rt, 1 = rd.
- mem_to_reg  output  1  0 = ALUOut, 1 = Data.
- reg_write  output  1  register file write.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- instr_cnt  output  32  count of fetched instructions.

Function
REQ-003 SHALL be a Moore FSM; all outputs SHALL decode from state only, except pc_en, ir_write and the mem_ready gating defined below.
REQ-004 SHALL have states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-005 IDLE: all outputs 0; SHALL go to FETCH unconditionally.
REQ-006 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
- SHALL hold FETCH while mem_ready=0.
- When mem_ready=1: ir_write=1, pc_en=1, instr_cnt increments, next state DECODE.
REQ-007 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
- Next state by op: 100011/101011 -> MEMADR, 000000 -> RTYPEEX, 000100 -> BEQEX, 001000 -> ADDIEX, 000010 -> JEX.
- Any other op -> FETCH, with illegal_op=1 for that DECODE cycle.
REQ-008 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEMRD if op=100011, else MEMWR.
REQ-009 MEMRD: mem_req=1, iord=1; SHALL hold until mem_ready=1, then go to MEMWB.
REQ-010 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next state FETCH.
REQ-011 MEMWR: mem_req=1, mem_write=1, iord=1; SHALL hold until mem_ready=1, then go to FETCH.
REQ-012 RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10; next state RTYPEWB.
REQ-013 RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-014 BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero (combinational); next state FETCH.
REQ-015 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDIWB.
REQ-016 ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-017 JEX: pc_src=10, pc_en=1; next state FETCH.
REQ-018 Outputs not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-019 instr_cnt SHALL wrap from 0xFFFFFFFF to 0 without a flag.
REQ-020 Latencies with mem_ready=1:
- lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-021 op SHALL be sampled only in DECODE and MEMADR.

Reset
REQ-022 reset SHALL force state IDLE and instr_cnt=0 asynchronously, with all outputs 0.
REQ-023 Reset asserted mid-access, including with mem_req=1, SHALL abort the access immediately; no ir_write, pc_en or reg_write SHALL follow.
REQ-024 After reset deasserts, the first FETCH SHALL occur on the second rising edge.

Structure
REQ-025 Package mips_ctrl_pkg SHALL hold:
- state enum ctrl_state_t;
- opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
- alu_op constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
REQ-026 One sub-module, mips_ctrl_outdec, SHALL provide the combinational state-to-control decode; the state register, next-state logic and counter SHALL reside in the top module.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, then op=100011, mem_ready=1 -> states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 with mem_to_reg=1 in the 6th cycle; instr_cnt=1.
- op=000100: zero=1 -> pc_en=1, pc_src=01 in BEQEX; zero=0 -> pc_en=0.
- op=101011 with mem_ready held 0 for 3 cycles in MEMWR -> mem_write stays 1 for 4 cycles, then FETCH.
- op=111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH; reg_write and mem_write never assert.
- Reset asserted while in MEMRD -> outputs 0 in the same cycle, state IDLE, instr_cnt=0.
- instr_cnt forced to 0xFFFFFFFF, one fetch completes -> instr_cnt=0.
